// File: rtl/microwave_control_if.sv
// Panel, door and timer inputs plus the magnetron enable for the microwave controller.
// The panel side is the master; the controller is the slave.
interface microwave_control_if;
  logic startn;
  logic stopn;
  logic clearn;
  logic door_closed;
  logic timer_done;
  logic mag;

  modport master (
    output startn,
    output stopn,
    output clearn,
    output door_closed,
    output timer_done,
    input  mag
  );

  modport slave (
    input  startn,
    input  stopn,
    input  clearn,
    input  door_closed,
    input  timer_done,
    output mag
  );
endinterface

// File: rtl/microwave_control.sv
// Magnetron-enable controller: synchronizes the panel/door/timer levels and runs an
// IDLE/COOK/PAUSED state machine whose registered output drives the magnetron.
module microwave_control #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  microwave_control_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    COOK   = 2'b01,
    PAUSED = 2'b10
  } state_t;

  logic [SYNC_STAGES-1:0] startn_q;
  logic [SYNC_STAGES-1:0] stopn_q;
  logic [SYNC_STAGES-1:0] clearn_q;
  logic [SYNC_STAGES-1:0] door_closed_q;
  logic [SYNC_STAGES-1:0] timer_done_q;

  logic   startn_s;
  logic   stopn_s;
  logic   clearn_s;
  logic   door_closed_s;
  logic   timer_done_s;
  logic   start_req;
  logic   stop_req;
  logic   clr_req;
  logic   door_ok;
  logic   done;
  state_t state;
  state_t state_nxt;
  logic   mag_r;

  // Chains reset to the inactive levels so nothing can request cooking right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      startn_q      <= '1;
      stopn_q       <= '1;
      clearn_q      <= '1;
      door_closed_q <= '0;
      timer_done_q  <= '0;
    end else begin
      startn_q      <= {startn_q[SYNC_STAGES-2:0], bus.startn};
      stopn_q       <= {stopn_q[SYNC_STAGES-2:0], bus.stopn};
      clearn_q      <= {clearn_q[SYNC_STAGES-2:0], bus.clearn};
      door_closed_q <= {door_closed_q[SYNC_STAGES-2:0], bus.door_closed};
      timer_done_q  <= {timer_done_q[SYNC_STAGES-2:0], bus.timer_done};
    end
  end

  assign startn_s      = startn_q[SYNC_STAGES-1];
  assign stopn_s       = stopn_q[SYNC_STAGES-1];
  assign clearn_s      = clearn_q[SYNC_STAGES-1];
  assign door_closed_s = door_closed_q[SYNC_STAGES-1];
  assign timer_done_s  = timer_done_q[SYNC_STAGES-1];

  assign start_req = !startn_s;
  assign stop_req  = !stopn_s;
  assign clr_req   = !clearn_s;
  assign door_ok   = door_closed_s;
  assign done      = timer_done_s;

  // Priority: clear > timer done > door open > stop > start.
  function automatic state_t next_state(
    input state_t cur,
    input logic   start_r,
    input logic   stop_r,
    input logic   clr_r,
    input logic   door_r,
    input logic   done_r
  );
    next_state = IDLE;
    case (cur)
      IDLE: begin
        if (clr_r || done_r)                   next_state = IDLE;
        else if (start_r && door_r && !stop_r) next_state = COOK;
        else                                   next_state = IDLE;
      end
      COOK: begin
        if (clr_r)                  next_state = IDLE;
        else if (done_r)            next_state = IDLE;
        else if (!door_r || stop_r) next_state = PAUSED;
        else                        next_state = COOK;
      end
      PAUSED: begin
        if (clr_r || done_r)                   next_state = IDLE;
        else if (start_r && door_r && !stop_r) next_state = COOK;
        else                                   next_state = PAUSED;
      end
      default: next_state = IDLE;
    endcase
  endfunction

  always_comb begin
    state_nxt = next_state(state, start_req, stop_req, clr_req, door_ok, done);
  end

  // mag is registered from the next state so it changes on the same edge as state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mag_r <= 1'b0;
    end else begin
      state <= state_nxt;
      mag_r <= (state_nxt == COOK);
    end
  end

  assign bus.mag = mag_r;

endmodule

// File: tb/tb_microwave_control.sv
// Bench for microwave_control: directed scenarios plus random panel activity,
// compared against a delayed-request oven model.
module tb_microwave_control;
  localparam int SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  microwave_control_if bus ();

  microwave_control #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: mag observed %b, expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Oven model: requests reach the decision logic SYNC_STAGES edges after being sampled.
  typedef struct packed {
    logic start;
    logic stop;
    logic clr;
    logic door;
    logic done;
  } req_t;

  typedef enum int { M_IDLE, M_COOK, M_PAUSED } mode_t;

  mode_t mode;
  req_t  pipe[$];

  function automatic mode_t rule(input mode_t m, input req_t r);
    if (r.clr) return M_IDLE;
    if (m == M_COOK) begin
      if (r.done) return M_IDLE;
      if (!r.door || r.stop) return M_PAUSED;
      return M_COOK;
    end
    if (r.done) return M_IDLE;
    if (r.start && r.door && !r.stop) return M_COOK;
    return m;
  endfunction

  task automatic model_reset();
    req_t safe;
    safe = '0;
    mode = M_IDLE;
    pipe.delete();
    for (int i = 0; i < SYNC_STAGES; i++) pipe.push_back(safe);
  endtask

  task automatic drive(input logic s, input logic p, input logic c, input logic d, input logic t);
    bus.startn      = s;
    bus.stopn       = p;
    bus.clearn      = c;
    bus.door_closed = d;
    bus.timer_done  = t;
  endtask

  // Advance one edge, update the model from the delayed request, compare 1 time unit later.
  task automatic step(input string tag);
    req_t r;
    @(posedge clk);
    r.start = !bus.startn;
    r.stop  = !bus.stopn;
    r.clr   = !bus.clearn;
    r.door  = bus.door_closed;
    r.done  = bus.timer_done;
    pipe.push_back(r);
    mode = rule(mode, pipe.pop_front());
    #1;
    check(tag, bus.mag, mode == M_COOK);
  endtask

  // Assert reset between edges, hold it for a few edges, release between edges.
  task automatic async_reset(input string tag, input int hold);
    #2;
    rst_n = 1'b0;
    #1;
    check(tag, bus.mag, 1'b0);
    model_reset();
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int next_change;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    model_reset();
    #1;
    check("reset_mag", bus.mag, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with door closed and nothing pressed.
    repeat (10) step("idle_hold");

    // Start pulse: mag rises on the third edge and latches.
    bus.startn = 1'b0;
    step("start_e1");
    bus.startn = 1'b1;
    step("start_e2");
    check("start_not_early", bus.mag, 1'b0);
    step("start_e3");
    check("start_lat3", bus.mag, 1'b1);
    repeat (5) step("cook_hold");

    // Door opens mid-cook, closes again, then start resumes.
    bus.door_closed = 1'b0;
    step("door_e1");
    step("door_e2");
    check("door_not_early", bus.mag, 1'b1);
    step("door_e3");
    check("door_pause", bus.mag, 1'b0);
    bus.door_closed = 1'b1;
    repeat (5) step("paused_hold");
    check("paused_no_resume", bus.mag, 1'b0);
    bus.startn = 1'b0;
    repeat (3) step("resume");
    check("resume_lat3", bus.mag, 1'b1);
    bus.startn = 1'b1;
    repeat (2) step("cook_hold2");

    // Timer done ends cooking; start is ignored while done is high.
    bus.timer_done = 1'b1;
    repeat (3) step("done_stop");
    check("done_idle", bus.mag, 1'b0);
    bus.startn = 1'b0;
    repeat (6) step("done_blocks_start");
    check("done_blocks_start_end", bus.mag, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (4) step("release_done");

    // Start with stop, and start with clear, never cook.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (6) step("start_stop");
    check("start_stop_off", bus.mag, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) step("release_ss");
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (6) step("start_clear");
    check("start_clear_off", bus.mag, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) step("release_sc");

    // Cook, pause with stop, clear from pause, then start again.
    bus.startn = 1'b0;
    step("cook2_e1");
    bus.startn = 1'b1;
    repeat (4) step("cook2");
    bus.stopn = 1'b0;
    step("stop_e1");
    bus.stopn = 1'b1;
    repeat (4) step("stop_pause");
    check("stop_paused", bus.mag, 1'b0);
    bus.clearn = 1'b0;
    step("clear_e1");
    bus.clearn = 1'b1;
    repeat (4) step("clear_idle");
    bus.startn = 1'b0;
    step("restart_e1");
    bus.startn = 1'b1;
    repeat (2) step("restart");
    check("restart_cook", bus.mag, 1'b1);

    // Asynchronous reset mid-cook; release with start held.
    bus.startn = 1'b0;
    async_reset("rst_mid_cook", 2);
    step("rst_rel_e1");
    step("rst_rel_e2");
    check("rst_rel_not_early", bus.mag, 1'b0);
    step("rst_rel_e3");
    check("rst_rel_lat3", bus.mag, 1'b1);
    bus.startn = 1'b1;
    repeat (2) step("post_rst");

    // Random panel activity with occasional asynchronous resets.
    next_change = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc >= next_change) begin
        bus.startn      = ($urandom_range(0, 3) != 0);
        bus.stopn       = ($urandom_range(0, 5) != 0);
        bus.clearn      = ($urandom_range(0, 11) != 0);
        bus.door_closed = ($urandom_range(0, 4) != 0);
        bus.timer_done  = ($urandom_range(0, 9) == 0);
        next_change     = cyc + $urandom_range(1, 8);
      end
      if ($urandom_range(0, 399) == 0) async_reset("rand_reset", $urandom_range(0, 3));
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
